// File: rtl/ib_lut_port_arbiter_pkg.sv
// Shared types, default parameters and width helpers for the IB LUT port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ib_lut_arb_pkg;

  // Which kind of access owns the SRAM port this cycle
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_BITWIDTH = 6;
  localparam int DEF_PAGE_SIZE     = 4;
  localparam int DEF_REQ_NUM       = 4;
  localparam int DEF_SYNC_RD       = 1;
  localparam int DEF_WR_BURST_MAX  = 8;

  // Round-robin pointer width; never below 1 bit
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Write burst counter must hold WR_BURST_MAX itself; kept at 4 bits minimum
  function automatic int burst_cnt_width(input int m);
    int w;
    w = $clog2(m + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/ib_lut_port_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after i_ptr, wrapping modulo REQ_NUM.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int PTR_W   = 2
) (
  input  logic [REQ_NUM-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [REQ_NUM-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx
);

  logic w_found;

  // Scan lanes starting at the pointer; modulo handles non-power-of-2 lane counts
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!w_found && i_req[(int'(i_ptr) + i) % REQ_NUM]) begin
        w_found = 1'b1;
        o_gnt[(int'(i_ptr) + i) % REQ_NUM] = 1'b1;
        o_idx = PTR_W'((int'(i_ptr) + i) % REQ_NUM);
      end
    end
  end

endmodule

// File: rtl/ib_lut_port_arbiter.sv
// Shares one single-port IB LUT SRAM between a loader (writes) and REQ_NUM read lanes.
// Latency: grants combinational; read response exactly 1 cycle after grant in both SRAM modes.
// Backpressure: wr_ready_o / rd_gnt_o stall requesters; responses cannot be stalled.
module ib_lut_port_arbiter
  import ib_lut_arb_pkg::*;
#(
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter int PAGE_SIZE     = DEF_PAGE_SIZE,
  parameter int REQ_NUM       = DEF_REQ_NUM,
  parameter int SYNC_RD       = DEF_SYNC_RD,
  parameter int WR_BURST_MAX  = DEF_WR_BURST_MAX
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  input  logic [ADDR_BITWIDTH-1:0]         wr_addr_i,
  input  logic [PAGE_SIZE-1:0]             wr_data_i,
  input  logic [REQ_NUM-1:0]               rd_req_i,
  input  logic [REQ_NUM*ADDR_BITWIDTH-1:0] rd_addr_i,
  output logic [REQ_NUM-1:0]               rd_gnt_o,
  output logic [REQ_NUM-1:0]               rd_valid_o,
  output logic [PAGE_SIZE-1:0]             rd_data_o,
  output logic [ADDR_BITWIDTH-1:0]         sram_addr_o,
  output logic [PAGE_SIZE-1:0]             sram_wdata_o,
  output logic                             sram_wen_n_o,
  input  logic [PAGE_SIZE-1:0]             sram_rdata_i
);

  localparam int PTR_W = ptr_width(REQ_NUM);
  localparam int CNT_W = burst_cnt_width(WR_BURST_MAX);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(WR_BURST_MAX);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(REQ_NUM - 1);

  logic [PTR_W-1:0]         r_rr_ptr;
  logic [CNT_W-1:0]         r_wr_burst_cnt;
  logic [REQ_NUM-1:0]       r_resp_tag;

  arb_state_e               w_state;
  logic                     w_any_rd;
  logic [REQ_NUM-1:0]       w_rr_gnt;
  logic [PTR_W-1:0]         w_rr_idx;
  logic [ADDR_BITWIDTH-1:0] w_rd_addr;

  assign w_any_rd  = |rd_req_i;
  assign w_rd_addr = rd_addr_i[int'(w_rr_idx)*ADDR_BITWIDTH +: ADDR_BITWIDTH];

  rr_arbiter #(
    .REQ_NUM (REQ_NUM),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req (rd_req_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx)
  );

  // Pick the port owner: writes win until the burst cap is hit with a read waiting
  always_comb begin
    w_state = ARB_IDLE;
    if (!sys_rst) begin
      if (wr_valid_i && (!w_any_rd || (r_wr_burst_cnt < BURST_MAX))) begin
        w_state = ARB_WRITE;
      end else if (w_any_rd) begin
        w_state = ARB_READ;
      end
    end
  end

  // Drive the SRAM port and handshakes from the chosen owner
  always_comb begin
    wr_ready_o   = (w_state == ARB_WRITE);
    sram_wen_n_o = (w_state != ARB_WRITE);
    rd_gnt_o     = (w_state == ARB_READ) ? w_rr_gnt : '0;
    sram_wdata_o = wr_data_i;
    case (w_state)
      ARB_WRITE: sram_addr_o = wr_addr_i;
      ARB_READ:  sram_addr_o = w_rd_addr;
      default:   sram_addr_o = '0;
    endcase
  end

  // Pointer, burst counter and response tag; the tag marks which lane gets next cycle's data
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rr_ptr       <= '0;
      r_wr_burst_cnt <= '0;
      r_resp_tag     <= '0;
    end else begin
      r_resp_tag <= rd_gnt_o;
      case (w_state)
        ARB_WRITE: begin
          if (!w_any_rd) begin
            r_wr_burst_cnt <= '0;
          end else if (r_wr_burst_cnt != BURST_MAX) begin
            r_wr_burst_cnt <= r_wr_burst_cnt + CNT_W'(1);
          end
        end
        ARB_READ: begin
          r_wr_burst_cnt <= '0;
          r_rr_ptr       <= (w_rr_idx == LAST_LANE) ? '0 : w_rr_idx + PTR_W'(1);
        end
        default: begin
          r_wr_burst_cnt <= '0;
        end
      endcase
    end
  end

  assign rd_valid_o = r_resp_tag;

  // Equalise read latency: registered macros pass through, combinational macros get a flop here
  generate
    if (SYNC_RD != 0) begin : g_sync_rd
      assign rd_data_o = (|r_resp_tag) ? sram_rdata_i : '0;
    end else begin : g_async_rd
      logic [PAGE_SIZE-1:0] r_rd_data;
      // Capture combinational read data in the grant cycle
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          r_rd_data <= '0;
        end else if (w_state == ARB_READ) begin
          r_rd_data <= sram_rdata_i;
        end
      end
      assign rd_data_o = r_rd_data;
    end
  endgenerate

  a_gnt_onehot0: assert property (@(posedge sys_clk) $onehot0(rd_gnt_o));
  a_wr_rd_excl:  assert property (@(posedge sys_clk) !(wr_ready_o && (|rd_gnt_o)));
  a_wen_matches: assert property (@(posedge sys_clk) (!sram_wen_n_o) == wr_ready_o);

endmodule
